window_addr_seq: RTL and testbench

- Sequential, parametrised successor to the fixed combinational window-address generator.
- Emits the byte addresses of a WIN_ROWS x WIN_COLS pixel window inside a row-major frame, one address per cycle, over a valid/ready stream.
- Sits between the frame-scan controller (supplies the linear window offset) and the memory read port.

---
 rtl/window_addr_seq_if.sv | 23 ++
 rtl/window_addr_seq.sv | 154 +++++++++++++++
 tb/tb_window_addr_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/window_addr_seq_if.sv
// Address stream between window_addr_seq and the memory read port.
// The master drives valid, address and sideband flags; the slave drives ready.
interface window_addr_seq_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 5
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  addr_idx;
  logic              addr_last;
  logic              addr_oob;

  modport master (
    output addr_valid, addr, addr_idx, addr_last, addr_oob,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, addr_idx, addr_last, addr_oob,
    output addr_ready
  );
endinterface

// File: rtl/window_addr_seq.sv
// Streams the byte addresses of a WIN_ROWS x WIN_COLS window, column block by column block.
// Optional out-of-frame flag built only when WIN_ADDR_BOUNDS_CHECK_EN is defined.
module window_addr_seq #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BASE_ADDR  = 16,
  parameter int unsigned FRAME_COLS = 64,
  parameter int unsigned FRAME_ROWS = 64,
  parameter int unsigned WIN_ROWS   = 4,
  parameter int unsigned WIN_COLS   = 8,
  parameter int unsigned BLK_COLS   = 4,
  parameter int unsigned COL_OFFSET = 4,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] win_offset,
  output logic              busy,
  output logic              done,
  window_addr_seq_if.master addr_if
);

  localparam int unsigned N     = WIN_ROWS * WIN_COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam int unsigned RW    = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;

  localparam logic [CW-1:0]     CMax       = CW'(BLK_COLS - 1);
  localparam logic [RW-1:0]     RMax       = RW'(WIN_ROWS - 1);
  localparam logic [IDX_W-1:0]  IdxLast    = IDX_W'(N - 1);
  localparam logic [ADDR_W-1:0] WordBytes  = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] StartConst = ADDR_W'(BASE_ADDR + WORD_BYTES * COL_OFFSET);
  localparam logic [ADDR_W-1:0] RowStep    = ADDR_W'(WORD_BYTES * FRAME_COLS);
  localparam logic [ADDR_W-1:0] BlkStep    = ADDR_W'(WORD_BYTES * BLK_COLS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  if ((WIN_COLS % BLK_COLS) != 0 || FRAME_ROWS == 0) begin : g_bad_cfg
    $error("window_addr_seq: WIN_COLS must be a multiple of BLK_COLS and FRAME_ROWS nonzero");
  end

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Address of column 0 in the current row and of row 0 in the current block.
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] blk_base_q, blk_base_d;
  logic [ADDR_W-1:0] start_addr;
  logic              run, last, hs;

  assign run        = (state_q == StRun);
  assign last       = run && (idx_q == IdxLast);
  assign hs         = run && addr_if.addr_ready;
  assign start_addr = StartConst + win_offset * WordBytes;

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    r_d        = r_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    blk_base_d = blk_base_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          c_d        = '0;
          r_d        = '0;
          idx_d      = '0;
          addr_d     = start_addr;
          row_base_d = start_addr;
          blk_base_d = start_addr;
        end
      end
      StRun: begin
        if (hs) begin
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (c_q != CMax) begin
              c_d    = c_q + CW'(1);
              addr_d = addr_q + WordBytes;
            end else if (r_q != RMax) begin
              c_d        = '0;
              r_d        = r_q + RW'(1);
              row_base_d = row_base_q + RowStep;
              addr_d     = row_base_d;
            end else begin
              c_d        = '0;
              r_d        = '0;
              blk_base_d = blk_base_q + BlkStep;
              row_base_d = blk_base_d;
              addr_d     = blk_base_d;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      c_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      blk_base_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      blk_base_q <= blk_base_d;
    end
  end

`ifdef WIN_ADDR_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FrameEnd =
      ADDR_W'(BASE_ADDR + WORD_BYTES * FRAME_ROWS * FRAME_COLS);
  logic oob_q, oob_d;

  // Judged on the next address so the flag lines up with the registered addr.
  assign oob_d = (addr_d >= FrameEnd) || (addr_d < BaseAddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob_q <= 1'b0;
    else        oob_q <= oob_d;
  end
  assign addr_if.addr_oob = oob_q;
`else
  assign addr_if.addr_oob = 1'b0;
`endif

  assign busy               = (state_q == StRun) || (state_q == StDone);
  assign done               = (state_q == StDone);
  assign addr_if.addr_valid = run;
  assign addr_if.addr       = addr_q;
  assign addr_if.addr_idx   = idx_q;
  assign addr_if.addr_last  = last;

endmodule

// File: tb/tb_window_addr_seq.sv
// Randomised scoreboard bench for window_addr_seq: expected beats come from the address formula.
module tb_window_addr_seq;
  localparam int unsigned BASE = 16, FC = 64, FR = 64, WR = 4, WC = 8, BC = 4, CO = 4, WB = 4;
  localparam int unsigned N = WR * WC;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  idx;
    logic        last;
    logic        oob;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] win_offset = '0;
  logic        busy, done;

  window_addr_seq_if #(.ADDR_W(32), .IDX_W(5)) aif ();

  window_addr_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .win_offset (win_offset),
    .busy       (busy),
    .done       (done),
    .addr_if    (aif.master)
  );

  always #5 clk = ~clk;

  beat_t q[$];
  int    total = 0, bad = 0;
  int    cyc = 0, done_cnt = 0, seq_base = 0, stall_seen = 0;
  int    first_cyc = -1, last_cyc = -1, done_cyc = -1;
  bit    exp_done = 1'b0;
  int    rdy_mode = 0;   // 0: always ready, 1: random
  int    stall_idx = -1, stall_left = 0;

  function automatic beat_t model(int unsigned k, logic [31:0] off);
    beat_t          t;
    int unsigned    b, rem, r, c;
    longint unsigned a;
    b   = k / (WR * BC);
    rem = k % (WR * BC);
    r   = rem / BC;
    c   = rem % BC;
    a   = longint'(BASE) + longint'(WB) * (longint'(r * FC + CO + b * BC + c) + longint'(off));
    t.addr = a[31:0];
    t.idx  = 5'(k);
    t.last = (k == N - 1);
`ifdef WIN_ADDR_BOUNDS_CHECK_EN
    t.oob = (t.addr >= 32'(BASE + WB * FR * FC)) || (t.addr < 32'(BASE));
`else
    t.oob = 1'b0;
`endif
    return t;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready driver: applied just after each rising edge, optionally stalling on one index.
  initial begin
    aif.addr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_idx >= 0 && aif.addr_valid && int'(aif.addr_idx) == stall_idx && stall_left > 0)
      begin
        aif.addr_ready = 1'b0;
        stall_left--;
      end else if (rdy_mode == 1) begin
        aif.addr_ready = ($urandom_range(0, 3) != 0);
      end else begin
        aif.addr_ready = 1'b1;
      end
    end
  end

  // Monitor: compares each presented beat with the queue front; pops on handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("done", done, exp_done);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      exp_done = 1'b0;
      if (aif.addr_valid) begin
        beat_t got;
        got = '{aif.addr, aif.addr_idx, aif.addr_last, aif.addr_oob};
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got addr=%0h idx=%0d want none", got.addr, got.idx);
        end else begin
          if (got != q[0]) begin
            bad++;
            $display("FAIL beat got addr=%0h idx=%0d last=%0b oob=%0b want addr=%0h idx=%0d last=%0b oob=%0b",
                     got.addr, got.idx, got.last, got.oob,
                     q[0].addr, q[0].idx, q[0].last, q[0].oob);
          end
          if (aif.addr_ready) begin
            if (q[0].idx == 5'd0) first_cyc = cyc;
            if (q[0].last) begin
              last_cyc = cyc;
              exp_done = 1'b1;
            end
            void'(q.pop_front());
          end else begin
            stall_seen++;
          end
        end
      end
    end
  end

  task automatic launch_seq(input logic [31:0] off, output int acc);
    for (int k = 0; k < int'(N); k++) q.push_back(model(k, off));
    seq_base = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    win_offset = off;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_seq(input string name);
    for (int i = 0; i < 3000 && done_cnt == seq_base; i++) @(posedge clk);
    check({name, "_done_count"}, done_cnt, seq_base + 1);
    check({name, "_queue_left"}, q.size(), 0);
    q.delete();
    @(posedge clk);
  endtask

  task automatic wait_idx(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (aif.addr_valid && int'(aif.addr_idx) == k) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_idx%0d got=timeout want=idx%0d", k, k);
    end
  endtask

  initial begin
    int acc;
    bit ok;
    #2;
    check("reset_outputs", {busy, done, aif.addr_valid, aif.addr, aif.addr_idx, aif.addr_last,
                            aif.addr_oob}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Back-to-back stream with timing checks.
    rdy_mode = 0;
    launch_seq(32'd0, acc);
    wait_seq("seq_default");
    check("first_latency", first_cyc, acc);
    check("last_cycle", last_cyc, acc + int'(N) - 1);
    check("done_cycle", done_cyc, acc + int'(N));

    // Backpressure on idx 5 for three cycles.
    stall_seen = 0;
    stall_idx = 5;
    stall_left = 3;
    launch_seq(32'd0, acc);
    wait_seq("seq_stall");
    check("stall_cycles", stall_seen, 3);
    stall_idx = -1;

    // Wrap modulo 2^32 with random backpressure.
    rdy_mode = 1;
    launch_seq(32'hFFFF_FFF0, acc);
    wait_seq("seq_wrap");

    // start while busy must be ignored.
    fork
      begin
        launch_seq(32'd0, acc);
        wait_seq("seq_busy_start");
      end
      begin
        wait_idx(10, ok);
        @(posedge clk);
        #1;
        start = 1'b1;
        win_offset = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join

    // Asynchronous reset mid-sequence.
    rdy_mode = 0;
    launch_seq(32'd0, acc);
    wait_idx(7, ok);
    #1 rst_n = 1'b0;
    #1;
    check("midseq_reset_outputs", {busy, done, aif.addr_valid, aif.addr, aif.addr_idx,
                                   aif.addr_last, aif.addr_oob}, 0);
    q.delete();
    exp_done = 1'b0;
    seq_base = done_cnt;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("no_done_after_reset", done_cnt, seq_base);
    check("idle_after_reset", busy, 0);
    launch_seq(32'd1, acc);
    wait_seq("seq_restart");

    // Window near the frame end exercises the bounds flag when built in.
    launch_seq(32'd4000, acc);
    wait_seq("seq_bounds");

    // Random offsets with random backpressure.
    rdy_mode = 1;
    for (int s = 0; s < 4; s++) begin
      launch_seq($urandom, acc);
      wait_seq("seq_random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
